execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter WORD_W, default 64, datapath width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  icode/ifun/valA/valB/valC valid from decode.
REQ-005 SHALL have port in_ready  output  1  execute can accept this cycle.
REQ-006 SHALL have port icode  input  4  instruction code.
REQ-007 SHALL have port ifun  input  4  function code.
REQ-008 SHALL have ports valA, valB, valC  input  WORD_W  decode operands and fetch constant.
REQ-009 SHALL have port out_valid  output  1  registered result valid toward memory stage.
REQ-010 SHALL have port out_ready  input  1  memory stage accepts result.
REQ-011 SHALL have port valE  output  WORD_W  ALU result.
REQ-012 SHALL have port cnd  output  1  branch/cmov condition.
REQ-013 SHALL have ports icode_out (4) and valA_out (WORD_W)  output  registered pass-through.
REQ-014 SHALL have port err  output  1  icode outside 0x0-0xB.

Function
REQ-015 SHALL drive in_ready = !out_valid | out_ready (single output register, no skid buffer).
REQ-016 SHALL accept on in_valid & in_ready; result registered at that edge, out_valid=1 next cycle (latency 1).
REQ-017 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-018 SHALL clear out_valid when out_ready=1 and no accept occurs in the same cycle; a same-cycle accept reloads the register.
REQ-019 SHALL compute valE: 2 cmovXX -> valA; 3 irmovq -> valC; 4/5 rmmovq/mrmovq -> valB+valC; 6 OPq -> valB op valA; 8/A call/pushq -> valB-8; 9/B ret/popq -> valB+8; 0/1/7 and illegal -> 0.
REQ-020 SHALL implement OPq ifun 0 add, 1 sub (valB-valA), 2 and, 3 xor; ifun>3 gives valE=0, err=1.
REQ-021 SHALL wrap all arithmetic modulo 2^WORD_W.
REQ-022 SHALL hold CC {ZF,SF,OF}, updated only on accepted OPq with legal ifun: ZF=(valE==0), SF=valE[MSB].
REQ-023 SHALL set OF: add when operands share sign and result differs; sub when valB,valA signs differ and result sign differs from valB; and/xor OF=0.
REQ-024 SHALL evaluate cnd for icode 2/7 from CC before the accept edge: ifun 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; >6 0.
REQ-025 SHALL drive cnd=0 for all other icodes.
REQ-026 SHALL make back-to-back OPq then jXX/cmovXX see the OPq's CC.
REQ-027 SHALL set err=1 for icode>0xB; CC unchanged, valE=0.

Reset
REQ-028 SHALL on rst: out_valid=0, valE=0, cnd=0, err=0, icode_out=0, valA_out=0, CC={ZF=1,SF=0,OF=0}.
REQ-029 SHALL discard any held result when rst asserts mid-transfer; in_valid ignored while rst=1.

Configuration
REQ-030 SHALL, with EXEC_CC_OUT_EN defined, add output cc_out[2:0]={ZF,SF,OF} reflecting the current CC register.
REQ-031 SHALL, without EXEC_CC_OUT_EN, omit cc_out; all other behaviour identical.

Structure
REQ-032 SHALL take icode constants (HALT..POPQ), OPq ifun codes and condition ifun codes from shared package y86_pkg.
REQ-033 SHALL place combinational ALU (operand select, op, OF/ZF/SF derivation) in sub-module exec_alu; CC register, cnd logic and handshake stay in execute.

Verification
REQ-034 SHALL cover: OPq add valA=111 valB=222 -> valE=333, CC=000, out_valid one cycle after accept.
REQ-035 SHALL cover: OPq sub valA=5 valB=5 -> valE=0, ZF=1; next jXX ifun 3 -> cnd=1; ifun 4 -> cnd=0.
REQ-036 SHALL cover: add valA=1 valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0x8000_0000_0000_0000, SF=1 OF=1; jXX ifun 2 -> cnd=0.
REQ-037 SHALL cover: pushq valB=555 -> valE=547; popq valB=555 -> valE=563; CC unchanged.
REQ-038 SHALL cover: out_ready=0 for 3 cycles -> in_ready=0, outputs stable; out_ready=1 with in_valid=1 -> accept same cycle, new result next cycle.
REQ-039 SHALL cover: rst while out_valid=1 after OPq setting ZF=0 -> next cycle out_valid=0, CC=100; icode=0xC -> err=1, valE=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, OPq functions, condition codes.
// Also defines the packed condition-code bundle used by the execute stage.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/exec_alu.sv
// Combinational execute ALU: operand selection, operation and flag derivation.
// o_set_cc is high only for an OPq with a legal function code.
module exec_alu
    import y86_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [3:0]        i_icode,
    input  logic [3:0]        i_ifun,
    input  logic [WORD_W-1:0] i_valA,
    input  logic [WORD_W-1:0] i_valB,
    input  logic [WORD_W-1:0] i_valC,
    output logic [WORD_W-1:0] o_valE,
    output logic              o_zf,
    output logic              o_sf,
    output logic              o_of,
    output logic              o_set_cc,
    output logic              o_err
);

    localparam int MSB = WORD_W - 1;
    localparam logic [WORD_W-1:0] STK_STEP = WORD_W'(8);

    logic [WORD_W-1:0] w_res;
    logic              w_of;

    always_comb begin
        w_res    = '0;
        w_of     = 1'b0;
        o_set_cc = 1'b0;
        o_err    = 1'b0;
        case (i_icode)
            I_CMOVXX: w_res = i_valA;
            I_IRMOVQ: w_res = i_valC;
            I_RMMOVQ,
            I_MRMOVQ: w_res = i_valB + i_valC;
            I_OPQ: begin
                o_set_cc = 1'b1;
                case (i_ifun)
                    A_ADD: begin
                        w_res = i_valB + i_valA;
                        w_of  = (i_valA[MSB] == i_valB[MSB])
                              & (w_res[MSB] != i_valA[MSB]);
                    end
                    A_SUB: begin
                        w_res = i_valB - i_valA;
                        w_of  = (i_valB[MSB] != i_valA[MSB])
                              & (w_res[MSB] != i_valB[MSB]);
                    end
                    A_AND: w_res = i_valB & i_valA;
                    A_XOR: w_res = i_valB ^ i_valA;
                    default: begin
                        o_set_cc = 1'b0;
                        o_err    = 1'b1;
                    end
                endcase
            end
            I_CALL,
            I_PUSHQ: w_res = i_valB - STK_STEP;
            I_RET,
            I_POPQ:  w_res = i_valB + STK_STEP;
            I_HALT,
            I_NOP,
            I_JXX:   w_res = '0;
            default: o_err = 1'b1;
        endcase
    end

    assign o_valE = w_res;
    assign o_zf   = (w_res == '0);
    assign o_sf   = w_res[MSB];
    assign o_of   = w_of;

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: single output register with valid/ready handshake.
// Define EXEC_CC_OUT_EN to expose the condition-code register as cc_out.
module execute
    import y86_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [WORD_W-1:0] valA,
    input  logic [WORD_W-1:0] valB,
    input  logic [WORD_W-1:0] valC,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] valE,
    output logic              cnd,
    output logic [3:0]        icode_out,
    output logic [WORD_W-1:0] valA_out,
    output logic              err
`ifdef EXEC_CC_OUT_EN
    ,
    output logic [2:0]        cc_out
`endif
);

    logic              r_out_valid;
    logic [WORD_W-1:0] r_valE;
    logic              r_cnd;
    logic [3:0]        r_icode;
    logic [WORD_W-1:0] r_valA;
    logic              r_err;
    cc_t               r_cc;

    logic [WORD_W-1:0] w_valE;
    logic              w_zf;
    logic              w_sf;
    logic              w_of;
    logic              w_set_cc;
    logic              w_err;
    logic              w_accept;
    logic              w_lt;
    logic              w_cond;
    logic              w_cnd;

    exec_alu #(
        .WORD_W (WORD_W)
    ) u_alu (
        .i_icode  (icode),
        .i_ifun   (ifun),
        .i_valA   (valA),
        .i_valB   (valB),
        .i_valC   (valC),
        .o_valE   (w_valE),
        .o_zf     (w_zf),
        .o_sf     (w_sf),
        .o_of     (w_of),
        .o_set_cc (w_set_cc),
        .o_err    (w_err)
    );

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // Conditions read the CC as it stood before this edge.
    assign w_lt = r_cc.sf ^ r_cc.of;

    always_comb begin
        w_cond = 1'b0;
        case (ifun)
            C_YES:   w_cond = 1'b1;
            C_LE:    w_cond = w_lt | r_cc.zf;
            C_L:     w_cond = w_lt;
            C_E:     w_cond = r_cc.zf;
            C_NE:    w_cond = ~r_cc.zf;
            C_GE:    w_cond = ~w_lt;
            C_G:     w_cond = ~w_lt & ~r_cc.zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_cnd = ((icode == I_CMOVXX) | (icode == I_JXX)) & w_cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_valE      <= '0;
            r_cnd       <= 1'b0;
            r_icode     <= '0;
            r_valA      <= '0;
            r_err       <= 1'b0;
            r_cc        <= CC_RESET;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_valE      <= w_valE;
            r_cnd       <= w_cnd;
            r_icode     <= icode;
            r_valA      <= valA;
            r_err       <= w_err;
            if (w_set_cc) begin
                r_cc <= '{zf: w_zf, sf: w_sf, of: w_of};
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign valE      = r_valE;
    assign cnd       = r_cnd;
    assign icode_out = r_icode;
    assign valA_out  = r_valA;
    assign err       = r_err;

`ifdef EXEC_CC_OUT_EN
    assign cc_out = {r_cc.zf, r_cc.sf, r_cc.of};
`endif

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed cases plus randomized traffic
// against a behavioural model of the Y86-64 execute rules.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd;
    logic [3:0]  icode_out;
    logic [63:0] valA_out;
    logic        err;
`ifdef EXEC_CC_OUT_EN
    logic [2:0]  cc_out;
`endif

    execute #(.WORD_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .valE      (valE),
        .cnd       (cnd),
        .icode_out (icode_out),
        .valA_out  (valA_out),
        .err       (err)
`ifdef EXEC_CC_OUT_EN
        ,
        .cc_out    (cc_out)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: architectural flags and the expected output register.
    bit          m_zf = 1'b1;
    bit          m_sf = 1'b0;
    bit          m_of = 1'b0;
    logic [63:0] e_valE;
    logic        e_cnd;
    logic        e_err;
    logic [3:0]  e_icode;
    logic [63:0] e_valA;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic bit cond_of(input logic [3:0] fn);
        bit less;
        less = (m_sf != m_of);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || m_zf;
            4'd2:    return less;
            4'd3:    return m_zf;
            4'd4:    return !m_zf;
            4'd5:    return !less;
            4'd6:    return !less && !m_zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c);
        logic [64:0] wide;
        logic [63:0] r;
        bit          ov;
        e_valE  = 64'd0;
        e_cnd   = 1'b0;
        e_err   = 1'b0;
        e_icode = ic;
        e_valA  = a;
        case (ic)
            4'h2: begin
                e_valE = a;
                e_cnd  = cond_of(fn);
            end
            4'h7: e_cnd = cond_of(fn);
            4'h3: e_valE = c;
            4'h4, 4'h5: e_valE = b + c;
            4'h6: begin
                ov = 1'b0;
                r  = 64'd0;
                if (fn > 4'd3) begin
                    e_err = 1'b1;
                end else begin
                    if (fn == 4'd0) begin
                        wide = {b[63], b} + {a[63], a};
                        r    = wide[63:0];
                        ov   = (wide != {r[63], r});
                    end else if (fn == 4'd1) begin
                        wide = {b[63], b} - {a[63], a};
                        r    = wide[63:0];
                        ov   = (wide != {r[63], r});
                    end else if (fn == 4'd2) begin
                        r = b & a;
                    end else begin
                        r = b ^ a;
                    end
                    e_valE = r;
                    m_zf   = (r == 64'd0);
                    m_sf   = r[63];
                    m_of   = ov;
                end
            end
            4'h8, 4'hA: e_valE = b - 64'd8;
            4'h9, 4'hB: e_valE = b + 64'd8;
            4'h0, 4'h1: e_valE = 64'd0;
            default: e_err = 1'b1;
        endcase
    endtask

    task automatic check_outs(input string tag);
        chkb({tag, ".out_valid"}, out_valid, 1'b1);
        chk({tag, ".valE"}, valE, e_valE);
        chkb({tag, ".cnd"}, cnd, e_cnd);
        chkb({tag, ".err"}, err, e_err);
        chk({tag, ".icode_out"}, 64'(icode_out), 64'(e_icode));
        chk({tag, ".valA_out"}, valA_out, e_valA);
`ifdef EXEC_CC_OUT_EN
        chk({tag, ".cc_out"}, 64'(cc_out), 64'({m_zf, m_sf, m_of}));
`endif
    endtask

    task automatic do_op(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input string tag);
        @(negedge clk);
        icode     = ic;
        ifun      = fn;
        valA      = a;
        valB      = b;
        valC      = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chkb({tag, ".in_ready"}, in_ready, 1'b1);
        model(ic, fn, a, b, c);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_outs(tag);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 1000));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0]  ric;
        logic [3:0]  rfn;
        logic [63:0] ra;
        logic [63:0] rb;

        // Reset with a live request that must be ignored.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        icode     = 4'h6;
        ifun      = 4'h0;
        valA      = 64'd1;
        valB      = 64'd2;
        valC      = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst.out_valid", out_valid, 1'b0);
        chk("rst.valE", valE, 64'd0);
        chkb("rst.cnd", cnd, 1'b0);
        chkb("rst.err", err, 1'b0);
        chk("rst.icode_out", 64'(icode_out), 64'd0);
        chk("rst.valA_out", valA_out, 64'd0);
        chkb("rst.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        do_op(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, "rst_cc_je");

        // Add, then flag probes.
        do_op(4'h6, 4'h0, 64'd111, 64'd222, 64'd0, "add333");
        do_op(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, "add333_jne");
        do_op(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, "add333_jl");

        // Sub to zero; back-to-back condition checks.
        do_op(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, "sub0");
        do_op(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, "sub0_je");
        do_op(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, "sub0_jne");

        // Signed overflow on add.
        do_op(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, "add_ovf");
        do_op(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, "add_ovf_jl");
        do_op(4'h2, 4'h1, 64'd77, 64'd0, 64'd0, "add_ovf_cmovle");

        // Stack pointer updates leave CC alone.
        do_op(4'hA, 4'h0, 64'd0, 64'd555, 64'd0, "pushq");
        do_op(4'hB, 4'h0, 64'd0, 64'd555, 64'd0, "popq");
        do_op(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, "stack_jl");
        do_op(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, "stack_je");
        do_op(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD_BEEF, "irmovq");
        do_op(4'h5, 4'h0, 64'd0, 64'd100, 64'd24, "mrmovq");

        // Back-pressure: hold the result for three cycles.
        do_op(4'h6, 4'h0, 64'd10, 64'd20, 64'd0, "stall_first");
        @(negedge clk);
        out_ready = 1'b0;
        icode     = 4'h6;
        ifun      = 4'h1;
        valA      = 64'd3;
        valB      = 64'd50;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chkb("stall.in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            check_outs("stall_hold");
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chkb("stall_release.in_ready", in_ready, 1'b1);
        model(4'h6, 4'h1, 64'd3, 64'd50, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_outs("stall_release");
        @(posedge clk);
        #1;
        chkb("drain.out_valid", out_valid, 1'b0);

        // Reset while a result is held.
        do_op(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, "pre_rst_add");
        @(negedge clk);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        chkb("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.valE", valE, 64'd0);
        chk("midrst.icode_out", 64'(icode_out), 64'd0);
        m_zf = 1'b1;
        m_sf = 1'b0;
        m_of = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        do_op(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, "midrst_je");
        do_op(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, "midrst_jne");

        // Illegal codes.
        do_op(4'hC, 4'h0, 64'd9, 64'd9, 64'd9, "bad_icode");
        do_op(4'h6, 4'h5, 64'd9, 64'd9, 64'd0, "bad_ifun");
        do_op(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, "bad_cc_je");

        // Randomized traffic with occasional idle cycles.
        for (int n = 0; n < 300; n++) begin
            ric = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ric = 4'h6;
            if ($urandom_range(0, 3) == 0) ric = 4'h7;
            rfn = 4'($urandom_range(0, 7));
            ra  = rnd64();
            rb  = ($urandom_range(0, 7) == 0) ? ra : rnd64();
            do_op(ric, rfn, ra, rb, rnd64(), "rand");
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                chkb("rand_idle.out_valid", out_valid, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
